// File: rtl/ifmap_packer.sv
// ifmap_packer: accepts a frame of raw ifmap elements (row_len * num_rows),
// tags each with start-of-row / end-of-row bits, buffers them in a small FIFO
// and presents them to the PE ifmap write port.
//   clk, rst_n         : clock, asynchronous active-low reset
//   start              : begin a frame (sampled only in IDLE)
//   row_len, num_rows  : frame geometry, latched on start
//   s_valid/s_data/s_ready : upstream element stream
//   m_data/m_wen/m_ready   : tagged output {sor, eor, element} to the PE
//   busy, done         : busy outside IDLE; done high for the single DONE cycle
module ifmap_packer #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_W      = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [CNT_W-1:0]      row_len,
  input  logic [CNT_W-1:0]      num_rows,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  output logic [DATA_WIDTH+1:0] m_data,
  output logic                  m_wen,
  input  logic                  m_ready,
  output logic                  busy,
  output logic                  done
);

  localparam int TW = 2 * CNT_W;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int WW = DATA_WIDTH + 2;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] row_len_q;
  logic [CNT_W-1:0] col_cnt;
  logic [CNT_W-1:0] row_cnt;
  logic [TW-1:0]    total;
  logic [TW-1:0]    acc_cnt;

  logic [WW-1:0]    mem [FIFO_DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  logic             fifo_empty;
  logic             fifo_full;
  logic             accept;
  logic             out_load;
  logic             pop;
  logic             push;
  logic             last_col;
  logic [WW-1:0]    in_word;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign s_ready  = (state == RUN) && !fifo_full && (acc_cnt < total);
  assign accept   = s_valid && s_ready;

  // The output register may take a new word when it is empty or being drained.
  assign out_load = !m_wen || m_ready;
  assign pop      = out_load && !fifo_empty;
  // With an empty FIFO and a free output register the accepted word goes
  // straight to the output register, giving one-cycle latency; otherwise it
  // queues behind the words already buffered so ordering is preserved.
  assign push     = accept && !(out_load && fifo_empty);

  assign last_col = (col_cnt == row_len_q - CNT_W'(1));
  assign in_word  = {(col_cnt == '0), last_col, s_data};

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= in_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      row_len_q <= '0;
      col_cnt   <= '0;
      row_cnt   <= '0;
      total     <= '0;
      acc_cnt   <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      m_wen     <= 1'b0;
      m_data    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            row_len_q <= row_len;
            total     <= TW'(row_len) * TW'(num_rows);
            acc_cnt   <= '0;
            col_cnt   <= '0;
            row_cnt   <= '0;
            state     <= (row_len == '0 || num_rows == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (accept) begin
            acc_cnt <= acc_cnt + TW'(1);
            if (last_col) begin
              col_cnt <= '0;
              row_cnt <= row_cnt + CNT_W'(1);
            end else begin
              col_cnt <= col_cnt + CNT_W'(1);
            end
            if (acc_cnt == total - TW'(1)) state <= FLUSH;
          end
        end
        FLUSH: begin
          if (fifo_empty && !m_wen) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase

      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);

      if (out_load) begin
        if (!fifo_empty) begin
          m_wen  <= 1'b1;
          m_data <= mem[rd_ptr[AW-1:0]];
        end else if (accept) begin
          m_wen  <= 1'b1;
          m_data <= in_word;
        end else begin
          m_wen  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ifmap_packer.sv
// Scoreboard bench for ifmap_packer: stimulus pushes expected tagged words,
// an independent monitor pops and compares on every output transfer.
module tb_ifmap_packer;

  localparam int DW = 16;
  localparam int CW = 4;
  localparam int WW = DW + 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] row_len = '0;
  logic [CW-1:0] num_rows = '0;
  logic          s_valid = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_ready;
  logic [WW-1:0] m_data;
  logic          m_wen;
  logic          m_ready = 1'b1;
  logic          busy;
  logic          done;

  int checks = 0;
  int failures = 0;
  int xfer_cnt = 0;
  int done_cnt = 0;
  logic [WW-1:0] exp_q[$];

  ifmap_packer #(.DATA_WIDTH(DW), .CNT_W(CW), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .row_len(row_len),
    .num_rows(num_rows), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .m_data(m_data), .m_wen(m_wen), .m_ready(m_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: scoreboard compare on each transfer, plus hold-stable check.
  logic          prev_stall = 1'b0;
  logic [WW-1:0] prev_data = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_wen", 32'(m_wen), 32'd1);
        check("hold_data", 32'(m_data), 32'(prev_data));
      end
      if (m_wen && m_ready) begin
        xfer_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_word", 32'(m_data), 32'hFFFF_FFFF);
        end else begin
          check("word", 32'(m_data), 32'(exp_q.pop_front()));
        end
      end
      if (done) done_cnt++;
      prev_stall = m_wen && !m_ready;
      prev_data  = m_data;
    end
  end

  function automatic logic [WW-1:0] tag(input int idx, input int rl, input logic [DW-1:0] d);
    logic sor, eor;
    sor = (idx % rl) == 0;
    eor = (idx % rl) == rl - 1;
    return {sor, eor, d};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int rl, input int nr);
    start = 1'b1;
    row_len = CW'(rl);
    num_rows = CW'(nr);
    cyc();
    start = 1'b0;
    row_len = 4'hF;   // later changes must not matter
    num_rows = 4'hF;
  endtask

  // Offer one element until accepted; expected word pushed at acceptance.
  task automatic send_elem(input logic [DW-1:0] d, input int idx, input int rl);
    bit got = 0;
    s_valid = 1'b1;
    s_data = d;
    for (int t = 0; t < 200 && !got; t++) begin
      @(negedge clk);
      if (s_ready) begin
        exp_q.push_back(tag(idx, rl, d));
        got = 1;
      end
      cyc();
    end
    if (!got) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_done(input int bound);
    int d0 = done_cnt;
    for (int t = 0; t < bound && done_cnt == d0; t++) @(negedge clk);
    #1;
    check("done_seen", 32'(done_cnt - d0), 32'd1);
  endtask

  initial begin
    int x0, acc;
    // Reset state
    #12;
    check("rst_s_ready", 32'(s_ready), 32'd0);
    check("rst_m_wen", 32'(m_wen), 32'd0);
    check("rst_m_data", 32'(m_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    cyc(); cyc();

    // row_len=4, num_rows=2, data 1..8, one-cycle latency check on first word
    x0 = xfer_cnt;
    do_start(4, 2);
    check("busy_run", 32'(busy), 32'd1);
    send_elem(16'd1, 0, 4);
    s_valid = 1'b0;
    @(negedge clk);
    check("latency_wen", 32'(m_wen), 32'd1);
    check("latency_data", 32'(m_data), 32'h2_0001);
    cyc();
    for (int i = 1; i < 8; i++) send_elem(16'(i + 1), i, 4);
    s_valid = 1'b0;
    wait_done(20);
    check("f1_xfers", 32'(xfer_cnt - x0), 32'd8);
    check("f1_queue", 32'(exp_q.size()), 32'd0);
    cyc();
    check("f1_idle", 32'(busy), 32'd0);

    // row_len=1, num_rows=3: both tags on every word
    x0 = xfer_cnt;
    do_start(1, 3);
    send_elem(16'hA, 0, 1);
    send_elem(16'hB, 1, 1);
    send_elem(16'hC, 2, 1);
    s_valid = 1'b0;
    wait_done(10);
    check("f2_xfers", 32'(xfer_cnt - x0), 32'd3);
    cyc();

    // Backpressure: 5 words absorbed (1 output + 4 FIFO), held stable
    x0 = xfer_cnt;
    acc = 0;
    m_ready = 1'b0;
    do_start(4, 2);
    s_valid = 1'b1;
    s_data = 16'h10;
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      if (s_ready) begin
        exp_q.push_back(tag(acc, 4, s_data));
        acc++;
      end
      cyc();
      s_data = 16'(16'h10 + acc);
    end
    check("stall_accepted", 32'(acc), 32'd5);
    @(negedge clk);
    check("stall_s_ready", 32'(s_ready), 32'd0);
    cyc();
    m_ready = 1'b1;
    for (int i = 5; i < 8; i++) send_elem(16'(16'h10 + i), i, 4);
    s_valid = 1'b0;
    wait_done(30);
    check("f3_xfers", 32'(xfer_cnt - x0), 32'd8);
    check("f3_queue", 32'(exp_q.size()), 32'd0);
    cyc();

    // row_len=0: straight to DONE, no output, s_ready low
    x0 = xfer_cnt;
    do_start(0, 3);
    @(negedge clk);
    check("zero_s_ready", 32'(s_ready), 32'd0);
    check("zero_done", 32'(done), 32'd1);
    wait_done(1);
    for (int t = 0; t < 3; t++) cyc();
    check("zero_xfers", 32'(xfer_cnt - x0), 32'd0);

    // Reset mid-frame after 3 of 8 elements (held back by m_ready=0)
    m_ready = 1'b0;
    do_start(4, 2);
    for (int i = 0; i < 3; i++) send_elem(16'(16'h30 + i), i, 4);
    s_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mrst_m_wen", 32'(m_wen), 32'd0);
    check("mrst_m_data", 32'(m_data), 32'd0);
    check("mrst_s_ready", 32'(s_ready), 32'd0);
    check("mrst_busy", 32'(busy), 32'd0);
    exp_q.delete();
    cyc();
    rst_n = 1'b1;
    m_ready = 1'b1;
    x0 = xfer_cnt;
    for (int t = 0; t < 4; t++) cyc();
    check("mrst_quiet", 32'(xfer_cnt - x0), 32'd0);
    do_start(2, 1);
    send_elem(16'h55, 0, 2);
    send_elem(16'h66, 1, 2);
    s_valid = 1'b0;
    wait_done(10);
    check("mrst_xfers", 32'(xfer_cnt - x0), 32'd2);
    cyc();

    // start re-pulsed during RUN with a different row_len is ignored
    x0 = xfer_cnt;
    do_start(2, 2);
    send_elem(16'h71, 0, 2);
    s_valid = 1'b0;
    start = 1'b1;
    row_len = 4'd3;
    num_rows = 4'd1;
    cyc();
    start = 1'b0;
    for (int i = 1; i < 4; i++) send_elem(16'(16'h71 + i), i, 2);
    s_valid = 1'b0;
    wait_done(10);
    check("restart_xfers", 32'(xfer_cnt - x0), 32'd4);
    check("restart_queue", 32'(exp_q.size()), 32'd0);
    cyc(); cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
